// File: rtl/wb_trace_capture.sv
// Write-back trace capture: records register-file writes into a show-ahead FIFO
// with overflow accounting. Define WB_TRACE_TIMESTAMP_EN to add per-entry cycle stamps.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | not capturing, FIFO empty or being consumed
//  RUN   | eligible write-back events are pushed into the FIFO
//  DRAIN | capture stopped, waiting for the consumer to empty the FIFO
module wb_trace_capture #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      capture_en,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [2:0]                wr_dest,
  input  logic [15:0]               wr_data,
  input  logic [PC_W-1:0]           pc,
  output logic                      trc_valid,
  input  logic                      trc_ready,
  output logic [2:0]                trc_dest,
  output logic [15:0]               trc_data,
  output logic [PC_W-1:0]           trc_pc,
`ifdef WB_TRACE_TIMESTAMP_EN
  output logic [31:0]               trc_stamp,
`endif
  output logic                      overflow,
  output logic [15:0]               drop_count,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 3 + 16 + PC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_run;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       w_rd_ptr_inc;
  logic [ENT_W-1:0]  w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_elig;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_empty_after_pop;
  logic              r_overflow;
  logic [15:0]       r_drop_count;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
  assign w_elig       = w_run && wr_en && (wr_dest != 3'd0);
  assign w_pop        = !w_empty && trc_ready;
  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign w_push       = w_elig && (!w_full || w_pop);
  assign w_drop       = w_elig && w_full && !w_pop;
  assign w_empty_after_pop = w_empty || (w_pop && (w_rd_ptr_inc == r_wr_ptr));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (capture_en) w_state_nxt = S_RUN;
      S_RUN:   if (!capture_en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (capture_en)             w_state_nxt = S_RUN;
        else if (w_empty_after_pop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  // State-decoded outputs
  always_comb begin
    w_run = 1'b0;
    if (r_state == S_RUN) w_run = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr[AW-1:0]] <= {wr_dest, wr_data, pc};
  end

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign trc_valid  = !w_empty;
  assign trc_dest   = w_empty ? 3'd0        : w_head[ENT_W-1 -: 3];
  assign trc_data   = w_empty ? 16'd0       : w_head[PC_W +: 16];
  assign trc_pc     = w_empty ? {PC_W{1'b0}} : w_head[PC_W-1:0];
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign level      = r_wr_ptr - r_rd_ptr;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] r_stamp_cnt;
  logic [31:0] r_stamp_mem [DEPTH];

  // Free-running; only reset restarts it, so stamps stay comparable across clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stamp_cnt <= '0;
    else        r_stamp_cnt <= r_stamp_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) r_stamp_mem[r_wr_ptr[AW-1:0]] <= r_stamp_cnt;
  end

  assign trc_stamp = w_empty ? 32'd0 : r_stamp_mem[r_rd_ptr[AW-1:0]];
`endif

endmodule
